// File: rtl/motor_step_seq.sv
// Stepper motor coil sequencer. Each rising edge of step_req advances
// the 3-bit phase index by one (half-step) or two (full-step) positions.
// It drives the matching coil pattern, tracks a signed position and then
// holds off further steps for a dwell period. A request edge that
// arrives while a step is in progress is dropped and recorded in the
// sticky missed_step flag.
module motor_step_seq #(
  parameter int DWELL_CYCLES = 1250,
  parameter int POS_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_req,
  input  logic             dir,
  input  logic             half_step,
  input  logic             enable,
  input  logic             clr_fault,
  output logic [3:0]       coil,
  output logic             busy,
  output logic             step_done,
  output logic [POS_W-1:0] position,
  output logic             missed_step
);

  // The dwell counter runs from 0 to DWELL_CYCLES-2, which gives
  // DWELL_CYCLES-1 cycles. With the single STEP cycle added, step_done
  // pulses are at least DWELL_CYCLES cycles apart.
  localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST =
    CNT_W'((DWELL_CYCLES >= 2) ? DWELL_CYCLES - 2 : 0);

  typedef enum logic [1:0] {IDLE, STEP, DWELL, WAIT_LOW} state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       phase_q, phase_d;
  logic [3:0]       coil_q, coil_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             missed_q, missed_d;

  logic             req_edge;
  logic             do_step;
  logic [2:0]       phase_inc;
  logic [POS_W-1:0] pos_inc;

  // armed_q stays low for the first clock after reset. This keeps a
  // step_req that is already high at reset release from looking like an edge.
  assign req_edge  = armed_q & step_req & ~req_q;
  assign phase_inc = half_step ? 3'd1 : 3'd2;
  assign pos_inc   = half_step ? POS_W'(1) : POS_W'(2);

  function automatic logic [3:0] coil_of(input logic [2:0] p);
    case (p)
      3'd0:    coil_of = 4'b1000;
      3'd1:    coil_of = 4'b1100;
      3'd2:    coil_of = 4'b0100;
      3'd3:    coil_of = 4'b0110;
      3'd4:    coil_of = 4'b0010;
      3'd5:    coil_of = 4'b0011;
      3'd6:    coil_of = 4'b0001;
      default: coil_of = 4'b1001;
    endcase
  endfunction

  // State register
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; dropping enable aborts any state back to IDLE
  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (req_edge) state_d = STEP;
        STEP:     state_d = DWELL;
        DWELL:    if (cnt_q == DWELL_LAST) state_d = step_req ? WAIT_LOW : IDLE;
        WAIT_LOW: if (!step_req) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: busy outside IDLE, step_done for the single STEP cycle
  always_comb begin
    busy      = (state_q != IDLE);
    step_done = (state_q == STEP) && enable;
  end

  assign do_step = step_done;

  // Datapath next values: dwell count, phase/position update, coil decode, fault flag
  always_comb begin
    req_d    = step_req;
    armed_d  = 1'b1;
    cnt_d    = '0;
    phase_d  = phase_q;
    pos_d    = pos_q;
    missed_d = missed_q;
    if (state_q == DWELL) cnt_d = cnt_q + CNT_W'(1);
    if (do_step) begin
      phase_d = dir ? phase_q + phase_inc : phase_q - phase_inc;
      pos_d   = dir ? pos_q + pos_inc : pos_q - pos_inc;
    end
    // The coil is decoded from the next phase so the new pattern and the
    // phase update land on the same edge. Disabling gives 0000 one edge later.
    coil_d = enable ? coil_of(phase_d) : 4'b0000;
    // A new missed edge takes priority over a coincident clear.
    if (req_edge && (state_q != IDLE)) missed_d = 1'b1;
    else if (clr_fault)                missed_d = 1'b0;
  end

  // Datapath registers
  // NOTE: every flop here is control/state, so all get an async reset; there is no memory array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q    <= 1'b0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 3'd0;
      coil_q   <= 4'b0000;
      pos_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      req_q    <= req_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      coil_q   <= coil_d;
      pos_q    <= pos_d;
      missed_q <= missed_d;
    end
  end

  assign coil        = coil_q;
  assign position    = pos_q;
  assign missed_step = missed_q;

endmodule

// File: doc/motor_step_seq.md
MOTOR_STEP_SEQ -- requirements
Module: motor_step_seq

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1250: minimum clock cycles between consecutive coil updates.
REQ-002 SHALL have parameter POS_W, default 16: width of position counter.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port step_req  input  1  stretched step request level from upstream pulse synchroniser.
REQ-006 SHALL have port dir  input  1  direction: 1 = forward (+), 0 = reverse (-).
REQ-007 SHALL have port half_step  input  1  1 = half-step mode, 0 = full-step mode.
REQ-008 SHALL have port enable  input  1  driver enable; 0 de-energises coils.
REQ-009 SHALL have port clr_fault  input  1  single-cycle clear of missed_step.
REQ-010 SHALL have port coil  output  4  coil drive pattern {A,B,C,D}.
REQ-011 SHALL have port busy  output  1  high while in any state other than IDLE.
REQ-012 SHALL have port step_done  output  1  single-cycle pulse on each coil update.
REQ-013 SHALL have port position  output  POS_W  signed step position, two's complement.
REQ-014 SHALL have port missed_step  output  1  sticky flag: request edge arrived while not in IDLE.

Function
REQ-015 SHALL detect a step request as a rising edge of step_req (registered previous value, 0 -> 1).
REQ-016 SHALL implement FSM states IDLE, STEP, DWELL, WAIT_LOW.
REQ-017 IDLE -> STEP on request edge with enable=1; edge with enable=0 SHALL be ignored and not flagged.
REQ-018 In STEP, dir and half_step SHALL be sampled, the 3-bit phase index updated, and step_done pulsed; the state then moves to DWELL. STEP lasts exactly one cycle.
REQ-019 Phase index update: half-step ±1 mod 8; full-step ±2 mod 8; + when dir=1, - when dir=0; wrap 7->0 and 0->7 (or 6->0 and 0->6 for full-step) without glitch.
REQ-020 coil SHALL be decoded from phase index: 0=1000, 1=1100, 2=0100, 3=0110, 4=0010, 5=0011, 6=0001, 7=1001.
REQ-021 coil SHALL change on the clock edge ending STEP, i.e. coil reflects the new phase one cycle after the request edge is registered (latency: edge cycle +2).
REQ-022 position SHALL add +1/-1 (half-step) or +2/-2 (full-step) in the same cycle as the phase update, wrapping modulo 2^POS_W.
REQ-023 DWELL SHALL count DWELL_CYCLES-1 cycles, so consecutive step_done pulses are separated by at least DWELL_CYCLES cycles.
REQ-024 After DWELL: if step_req=1, go to WAIT_LOW; else go to IDLE. WAIT_LOW -> IDLE when step_req=0.
REQ-025 A request edge detected in STEP, DWELL or WAIT_LOW SHALL set missed_step and SHALL NOT generate a step.
REQ-026 missed_step SHALL clear on clr_fault=1; if clr_fault and a new missed edge coincide, set wins.
REQ-027 enable=0 SHALL force coil=0000 combinationally-registered on the next edge, abort any state to IDLE, and retain phase index and position.
REQ-028 On enable returning to 1, coil SHALL show the pattern of the retained phase index on the next edge; no step is taken without a new request edge.
REQ-029 Full-step mode from odd phase index SHALL still step ±2 (two-coil drive); no realignment.
REQ-030 busy SHALL be 1 in STEP, DWELL, WAIT_LOW; 0 in IDLE.

Reset
REQ-031 rst=0 SHALL asynchronously force: state IDLE, phase index 0, coil 0000, position 0, busy 0, step_done 0, missed_step 0, edge-detect register 0.
REQ-032 After rst release with enable=1, coil SHALL read 1000 from the first clock edge; step_req already high at release SHALL NOT count as an edge.
REQ-033 Reset asserted mid-DWELL SHALL abandon the step sequence with no further step_done.

Verification
REQ-034 Half-step, dir=1, 9 request edges spaced 1300 cycles -> coil walks 1100,0100,...,1001,1000,1100; position=9; 9 step_done pulses.
REQ-035 Full-step, dir=0, from phase 0, 3 edges -> coil 0001, 0010, 0100; position=-6 (0xFFFA).
REQ-036 Second request edge 200 cycles after first -> no coil change, missed_step=1; clr_fault pulse -> missed_step=0.
REQ-037 step_req held high 3000 cycles -> exactly one step_done; busy stays 1 until step_req falls.
REQ-038 enable dropped mid-DWELL at phase 3 -> coil=0000, busy=0; enable restored -> coil=0110, position unchanged.
REQ-039 Position at 0x7FFF, one forward half-step -> position=0x8000.
